// File: rtl/mem_access_master_if.sv
// Request/response and memory-bus bundle for mem_access_master.
// The master modport is the block's own view; slave is the requester/memory side.
interface mem_access_master_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_mode;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic                  resp_valid;
  logic [WIDTH-1:0]      resp_rdata;
  logic                  resp_err;
  logic                  MemWrite;
  logic [1:0]            MemMode;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [WIDTH-1:0]      memWriteData;
  logic [WIDTH-1:0]      memReadData;

  modport master (
    input  req_valid, req_write, req_mode, req_signed, req_addr, req_wdata, memReadData,
    output req_ready, resp_valid, resp_rdata, resp_err, MemWrite, MemMode, memAddr, memWriteData
  );

  modport slave (
    output req_valid, req_write, req_mode, req_signed, req_addr, req_wdata, memReadData,
    input  req_ready, resp_valid, resp_rdata, resp_err, MemWrite, MemMode, memAddr, memWriteData
  );
endinterface

// File: rtl/mem_access_master.sv
// CPU load/store to word-only memory initiator: big-endian lanes, RMW sub-word stores.
// Define MEMACC_PERF_EN to add saturating load/store/rmw counters.
module mem_access_master #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int READ_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_master_if.master  bus
`ifdef MEMACC_PERF_EN
  ,
  output logic [15:0]          perf_loads,
  output logic [15:0]          perf_stores,
  output logic [15:0]          perf_rmw
`endif
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] RD_LAST = 2'(READ_LAT - 1);

  state_t                state, stateNext;
  logic                  readyQ, respValid, respErr, memWriteQ;
  logic                  writeQ, signedQ;
  logic [1:0]            modeQ, offQ, rdCnt;
  logic [15:0]           wdataQ;
  logic [ADDR_WIDTH-1:0] memAddrQ;
  logic [WIDTH-1:0]      respData, wrData, loadData, mergeData, laneMask, laneData;
  logic                  accept, misaligned, reqWord, rdLast, byteQ, halfQ;
  logic [4:0]            byteSh, halfSh;
  logic [7:0]            byteVal;
  logic [15:0]           halfVal;

  assign accept  = bus.req_valid && readyQ;
  assign reqWord = (bus.req_mode != 2'b01) && (bus.req_mode != 2'b10);
  assign rdLast  = (rdCnt == RD_LAST);
  assign byteQ   = (modeQ == 2'b10);
  assign halfQ   = (modeQ == 2'b01);

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_mode)
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = |bus.req_addr[1:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) begin
        if (misaligned)                      stateNext = RESP;
        else if (!bus.req_write || !reqWord) stateNext = RD;
        else                                 stateNext = WR;
      end
      RD:   if (rdLast) stateNext = writeQ ? WR : RESP;
      WR:   stateNext = RESP;
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Big-endian lanes: offset 0 is the most significant byte, hence the inverted offset.
  assign byteSh  = {~offQ, 3'b000};
  assign halfSh  = {~offQ[1], 4'b0000};
  assign byteVal = 8'(bus.memReadData >> byteSh);
  assign halfVal = 16'(bus.memReadData >> halfSh);

  always_comb begin
    loadData = bus.memReadData;
    laneMask = '0;
    laneData = '0;
    if (byteQ) begin
      loadData = {{(WIDTH-8){signedQ && byteVal[7]}}, byteVal};
      laneMask = {{(WIDTH-8){1'b0}}, 8'hFF} << byteSh;
      laneData = {{(WIDTH-8){1'b0}}, wdataQ[7:0]} << byteSh;
    end else if (halfQ) begin
      loadData = {{(WIDTH-16){signedQ && halfVal[15]}}, halfVal};
      laneMask = {{(WIDTH-16){1'b0}}, 16'hFFFF} << halfSh;
      laneData = {{(WIDTH-16){1'b0}}, wdataQ} << halfSh;
    end
    mergeData = (bus.memReadData & ~laneMask) | laneData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readyQ    <= 1'b0;
      respValid <= 1'b0;
      respErr   <= 1'b0;
      memWriteQ <= 1'b0;
      writeQ    <= 1'b0;
      signedQ   <= 1'b0;
      modeQ     <= '0;
      offQ      <= '0;
      rdCnt     <= '0;
      wdataQ    <= '0;
      memAddrQ  <= '0;
      respData  <= '0;
      wrData    <= '0;
    end else begin
      readyQ    <= (stateNext == IDLE);
      respValid <= (stateNext == RESP);
      memWriteQ <= (stateNext == WR);
      if (accept) begin
        writeQ   <= bus.req_write;
        modeQ    <= bus.req_mode;
        signedQ  <= bus.req_signed;
        offQ     <= bus.req_addr[1:0];
        wdataQ   <= bus.req_wdata[15:0];
        rdCnt    <= '0;
        respErr  <= misaligned;
        respData <= '0;
        if (!misaligned) memAddrQ <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
        if (!misaligned && bus.req_write && reqWord) wrData <= bus.req_wdata;
      end else if (state == RD) begin
        rdCnt <= rdCnt + 2'd1;
        if (rdLast) begin
          if (writeQ) wrData   <= mergeData;
          else        respData <= loadData;
        end
      end else if (state == RESP) begin
        respErr <= 1'b0;
      end
    end
  end

  assign bus.req_ready    = readyQ;
  assign bus.resp_valid   = respValid;
  assign bus.resp_rdata   = respData;
  assign bus.resp_err     = respErr;
  assign bus.MemWrite     = memWriteQ;
  assign bus.MemMode      = modeQ;
  assign bus.memAddr      = memAddrQ;
  assign bus.memWriteData = wrData;

`ifdef MEMACC_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_rmw    <= '0;
    end else if (state == RESP && !respErr) begin
      if (!writeQ) begin
        if (perf_loads != 16'hFFFF) perf_loads <= perf_loads + 16'd1;
      end else begin
        if (perf_stores != 16'hFFFF) perf_stores <= perf_stores + 16'd1;
        if ((byteQ || halfQ) && perf_rmw != 16'hFFFF) perf_rmw <= perf_rmw + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_master.sv
// Scoreboard bench: byte-array reference memory predicts responses and writes; a monitor checks them.
module tb_mem_access_master;
  localparam int W  = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_master_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();
  mem_access_master_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus3 ();

  mem_access_master #(.WIDTH(W), .ADDR_WIDTH(AW), .READ_LAT(1)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mem_access_master #(.WIDTH(W), .ADDR_WIDTH(AW), .READ_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct { logic load; logic err; logic [31:0] rdata; int lat; int acc; } exp_t;
  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;

  exp_t        expQ[$];
  wr_t         wrQ[$];
  logic [31:0] mem    [32];
  logic [31:0] refMem [32];
  int          cyc = 0;
  int          nTests = 0;
  int          nFail = 0;

  assign bus.memReadData  = mem[bus.memAddr[6:2]];
  assign bus3.memReadData = {8'hC3, 8'h00, bus3.memAddr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Memory: contents randomised once, then written by the DUT's write strobe.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    forever begin
      @(negedge clk);
      if (bus.MemWrite === 1'b1) mem[bus.memAddr[6:2]] = bus.memWriteData;
    end
  end

  // Monitor: pops expected writes/responses whenever the DUT presents one.
  initial begin
    exp_t e;
    wr_t  w;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.MemWrite === 1'b1) begin
        if (wrQ.size() == 0) begin
          nTests++; nFail++;
          $display("FAIL unexpected_write: got addr %h data %h, want no write", bus.memAddr, bus.memWriteData);
        end else begin
          w = wrQ.pop_front();
          check("wr_addr", {16'h0, bus.memAddr}, {16'h0, w.addr});
          check("wr_data", bus.memWriteData, w.data);
        end
      end
      if (bus.resp_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          nTests++; nFail++;
          $display("FAIL unexpected_resp: got rdata %h err %b, want no response", bus.resp_rdata, bus.resp_err);
        end else begin
          e = expQ.pop_front();
          check("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
          if (e.load) check("resp_rdata", bus.resp_rdata, e.rdata);
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  // Reference: treat each word as four bytes, byte 0 most significant.
  task automatic model(input logic wr, input logic [1:0] mode, input logic sgn,
                       input logic [15:0] addr, input logic [31:0] wdata);
    logic [7:0] b [4];
    exp_t e;
    wr_t  w;
    int   k   = int'(addr[1:0]);
    int   idx = int'(addr[6:2]);
    logic half = (mode == 2'b01);
    logic byt  = (mode == 2'b10);
    e.load  = !wr;
    e.err   = half ? addr[0] : (byt ? 1'b0 : (addr[1:0] != 2'b00));
    e.rdata = 32'h0;
    e.acc   = cyc;
    e.lat   = 1;
    if (!e.err) begin
      for (int j = 0; j < 4; j++) b[j] = refMem[idx][31-8*j -: 8];
      if (!wr) begin
        e.lat = 2;
        if (byt)       e.rdata = (sgn && b[k][7]) ? {24'hFFFFFF, b[k]} : {24'h0, b[k]};
        else if (half) e.rdata = (sgn && b[k][7]) ? {16'hFFFF, b[k], b[k+1]} : {16'h0, b[k], b[k+1]};
        else           e.rdata = refMem[idx];
      end else begin
        if (byt) begin
          b[k] = wdata[7:0]; e.lat = 3;
          refMem[idx] = {b[0], b[1], b[2], b[3]};
        end else if (half) begin
          b[k] = wdata[15:8]; b[k+1] = wdata[7:0]; e.lat = 3;
          refMem[idx] = {b[0], b[1], b[2], b[3]};
        end else begin
          e.lat = 2;
          refMem[idx] = wdata;
        end
        w.addr = {addr[15:2], 2'b00};
        w.data = refMem[idx];
        wrQ.push_back(w);
      end
    end
    expQ.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic [1:0] mode, input logic sgn,
                       input logic [15:0] addr, input logic [31:0] wdata);
    int t = 0;
    @(negedge clk);
    bus.req_write  = wr;
    bus.req_mode   = mode;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    while (bus.req_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (bus.req_ready !== 1'b1) begin
      nTests++; nFail++;
      $display("FAIL ready_timeout: got req_ready %b, want 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    model(wr, mode, sgn, addr, wdata);
    // Accepted at the next edge; a junk request while busy must be ignored.
    @(negedge clk);
    bus.req_write = 1'($urandom);
    bus.req_mode  = 2'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = $urandom;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((expQ.size() != 0 || wrQ.size() != 0) && t < 200) begin @(negedge clk); t++; end
    check("drain_pending", 32'(expQ.size() + wrQ.size()), 32'h0);
  endtask

  initial begin
    int acc, t;
    logic [15:0] a;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_mode = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_mode = 2'b00; bus3.req_signed = 1'b0;
    bus3.req_addr = '0; bus3.req_wdata = '0;
    #2;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) refMem[i] = mem[i];
    repeat (3) @(negedge clk);
    check("rst_req_ready",    {31'h0, bus.req_ready},  32'h0);
    check("rst_resp_valid",   {31'h0, bus.resp_valid}, 32'h0);
    check("rst_resp_err",     {31'h0, bus.resp_err},   32'h0);
    check("rst_resp_rdata",   bus.resp_rdata,          32'h0);
    check("rst_MemWrite",     {31'h0, bus.MemWrite},   32'h0);
    check("rst_MemMode",      {30'h0, bus.MemMode},    32'h0);
    check("rst_memAddr",      {16'h0, bus.memAddr},    32'h0);
    check("rst_memWriteData", bus.memWriteData,        32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);

    // Directed: word store/load, byte RMW, sub-word loads, misaligned half store.
    issue(1'b1, 2'b00, 1'b0, 16'h1004, 32'h11223344);
    issue(1'b0, 2'b00, 1'b0, 16'h1004, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 16'h1006, 32'h000000AB);
    issue(1'b0, 2'b00, 1'b0, 16'h1004, 32'h0);
    issue(1'b0, 2'b10, 1'b1, 16'h1006, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 16'h1006, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 16'h1004, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 16'h1001, 32'h0000BEEF);
    drain();
    check("mem_1004_after_rmw", mem[1], 32'h1122AB44);

    // Reset during the read phase of a byte store must commit nothing.
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_mode = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 16'h1005; bus.req_wdata = 32'h0000005A; bus.req_valid = 1'b1;
    t = 0;
    while (bus.req_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_MemWrite",   {31'h0, bus.MemWrite},   32'h0);
    check("abort_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    check("abort_req_ready",  {31'h0, bus.req_ready},  32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ready_after", {31'h0, bus.req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    check("abort_mem_unchanged", mem[1], 32'h1122AB44);
    issue(1'b0, 2'b00, 1'b0, 16'h1004, 32'h0);
    drain();

    // Randomised mix over a small window so RMW and loads collide on the same words.
    for (int n = 0; n < 150; n++)
      issue(1'($urandom), 2'($urandom), 1'($urandom), 16'h1000 + 16'($urandom_range(0, 31)), $urandom);
    drain();

    // READ_LAT=3 instance: back-to-back word loads with req_valid held high.
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      a = 16'h2000 + 16'(n * 4);
      bus3.req_addr  = a;
      bus3.req_valid = 1'b1;
      t = 0;
      while (bus3.req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      check("rl3_ready", {31'h0, bus3.req_ready}, 32'h1);
      acc = cyc;
      t = 0;
      do begin
        @(posedge clk); #1; t++;
        if (bus3.resp_valid !== 1'b1) check("rl3_busy_ready", {31'h0, bus3.req_ready}, 32'h0);
      end while (bus3.resp_valid !== 1'b1 && t < 20);
      check("rl3_resp_seen", {31'h0, bus3.resp_valid}, 32'h1);
      check("rl3_latency",   32'(cyc - acc), 32'd4);
      check("rl3_rdata",     bus3.resp_rdata, {8'hC3, 8'h00, a});
      check("rl3_resp_ready", {31'h0, bus3.req_ready}, 32'h0);
    end
    @(negedge clk);
    bus3.req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator side of the controller-to-memory interface: turns CPU load/store requests into MemWrite/MemMode/memAddr/memWriteData cycles and captures memReadData.
- Handles byte, half and word accesses using big-endian lane placement.
- Sub-word stores are done as read-modify-write against the word-only memory.
- Load results are aligned and optionally sign-extended.
- Sits between the multicycle controller/datapath and the ROM/RAM/IO memory decoder.

Parameters:
- WIDTH, 32, data width; only 32 is supported.
- ADDR_WIDTH, 16, byte-address width.
- READ_LAT, 1, cycles from address drive to valid memReadData; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; the block is held in reset while reset==0.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_mode  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- req_signed  input  1  sign-extend sub-word loads.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  WIDTH  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  WIDTH  aligned load result.
- resp_err  output  1  misaligned request; valid with resp_valid.
- MemWrite  output  1  memory write strobe.
- MemMode  output  2  registered copy of req_mode.
- memAddr  output  ADDR_WIDTH  word address; bits [1:0] always 0.
- memWriteData  output  WIDTH  full merged write word.
- memReadData  input  WIDTH  memory read data.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE.
  - req_ready=0 while in reset, then 1 in the first IDLE cycle after release.
  - resp_valid=0, resp_err=0, resp_rdata=0, MemWrite=0, MemMode=0, memAddr=0, memWriteData=0.
  - Internal RD counter cleared.
- Handshake:
  - A request is accepted on a clock edge with req_valid && req_ready.
  - req_ready is 1 only in IDLE.
  - All request fields are registered at acceptance.
  - Responses have no backpressure.
- Alignment check:
  - half requires addr[0]==0; word requires addr[1:0]==0.
  - A misaligned request goes IDLE->RESP with resp_err=1 and resp_rdata=0.
  - A misaligned request produces no memory cycle: MemWrite stays 0.
- FSM states: IDLE, RD, WR, RESP. All outputs are registered.
  - Load: IDLE->RD. In RD, memAddr={addr[15:2],2'b00}; stay READ_LAT cycles, sample memReadData on the last RD edge; then RESP.
  - Word store: IDLE->WR->RESP. In WR, MemWrite=1 for exactly one cycle and memWriteData=req_wdata.
  - Sub-word store: IDLE->RD->WR->RESP. The RD-captured word is merged with the new lanes; unaffected lanes are preserved bit-exact.
  - RESP: resp_valid=1 for one cycle, then IDLE. req_ready returns to 1 in the next cycle.
- Latencies (accept edge to resp_valid high, READ_LAT=1): load 2 cycles, word store 2, sub-word store 3, misaligned 1.
- Byte lanes (big-endian): byte offset k occupies bits [31-8k:24-8k]; half offset 0 -> [31:16], offset 2 -> [15:0].
- Load result: selected lane right-justified, then zero- or sign-extended per req_signed. Word loads ignore req_signed.
- memAddr and MemMode hold stable from the first RD/WR cycle until leaving WR/RD. MemWrite is never 1 outside WR.
- req_valid asserted in a non-IDLE state is ignored; the requester holds it.
- Reset asserted mid-operation: immediate abort, MemWrite drops asynchronously, no write is committed and no response is issued.

Optional Feature:
- MEMACC_PERF_EN.
- Defined: adds outputs perf_loads[15:0], perf_stores[15:0] and perf_rmw[15:0]:
  - Saturating counters, each incremented on the RESP cycle of a completed non-error access of its class.
  - Cleared by reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Word store 0x11223344 @0x1004 then word load @0x1004 -> MemWrite high 1 cycle with memAddr=0x1004; load resp_rdata=0x11223344, resp_err=0.
- Byte store 0xAB @0x1006 over 0x11223344 -> one RD, then WR with memWriteData=0x1122AB44; word load returns 0x1122AB44.
- Byte load @0x1006 with req_signed=1 -> 0xFFFFFFAB; req_signed=0 -> 0x000000AB; half load @0x1004 signed -> 0x00001122.
- Half store @0x1001 -> resp_valid 1 cycle after accept, resp_err=1, MemWrite never asserted, memory unchanged.
- Reset driven to 0 during RD of a sub-word store, then released -> MemWrite stays 0, req_ready=1 on the first cycle after release, target word unchanged.
- READ_LAT=3, back-to-back loads with req_valid held high -> each load resp_valid exactly 4 cycles after its accept; req_ready low between accept and RESP.
